// File: rtl/vnu_pe.sv
// ---------------------------------------------------------------------------
// vnu_pe : variable node processing element for a regular (3,6) LDPC decoder
//          (min-sum / phi flavour). Counterpart of the check node unit.
//
// For each variable node it takes the three check-to-variable messages and
// the stored channel LLR. It forms the posterior sum and the hard decision,
// then returns three extrinsic variable-to-check messages in the 6-bit
// {hard, sign, mag[3:0]} format that the check node unit consumes.
//
// Pipeline (both stages advance only when en=1):
//   stage 1 : message conversion, channel select, posterior total
//   stage 2 : extrinsic e_i = total - m_i, sign/magnitude, saturation, phi
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (priority over en and ch_load)
//   en         pipeline advance enable (channel register ignores it)
//   ch_load    capture ch_llr into the channel register
//   ch_llr     channel LLR, 6-bit two's complement
//   in_valid   Y[0:2] valid this cycle
//   Y[0:2]     check messages {sign, mag[3:0]}
//   X[0:2]     extrinsic messages {hard, sign, mag[3:0]}
//   out_valid  X / hard_bit valid
//   hard_bit   posterior hard decision (1 = total < 0)
//   iter_cnt   completed iterations of the current codeword
//   iter_last  iter_cnt == MAX_ITER-1
// ---------------------------------------------------------------------------
module vnu_pe #(
    parameter int USE_PHI  = 1,
    parameter int MAX_ITER = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ch_load,
    input  logic [5:0] ch_llr,
    input  logic       in_valid,
    input  logic [4:0] Y [0:2],
    output logic [5:0] X [0:2],
    output logic       out_valid,
    output logic       hard_bit,
    output logic [7:0] iter_cnt,
    output logic       iter_last
);

    localparam logic [7:0] LAST_ITER = 8'(MAX_ITER - 1);

    // Quantised phi(x) = -ln(tanh(x/2)), input and output LSB = 0.25,
    // rounded to nearest and saturated to 15 (phi(0) is infinite).
    function automatic logic [3:0] phi_lut(input logic [3:0] m);
        logic [3:0] r;
        case (m)
            4'd0:    r = 4'd15;
            4'd1:    r = 4'd8;
            4'd2:    r = 4'd6;
            4'd3:    r = 4'd4;
            4'd4:    r = 4'd3;
            4'd5:    r = 4'd2;
            4'd6:    r = 4'd2;
            4'd7:    r = 4'd1;
            4'd8:    r = 4'd1;
            4'd9:    r = 4'd1;
            4'd10:   r = 4'd1;
            4'd11:   r = 4'd1;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    logic signed [5:0] r_ch;
    logic signed [5:0] w_c;
    logic signed [5:0] w_m     [0:2];
    logic signed [7:0] w_total;

    logic signed [5:0] r_m     [0:2];
    logic signed [7:0] r_total;
    logic              r_v1;

    logic signed [7:0] w_e     [0:2];
    logic        [7:0] w_abs   [0:2];
    logic        [3:0] w_sat   [0:2];
    logic        [3:0] w_omag  [0:2];
    logic              w_hard;

    logic        [5:0] r_x     [0:2];
    logic              r_hard;
    logic              r_out_valid;
    logic        [7:0] r_iter;

    // ---------------------------------------------------------------------
    // Stage-1 combinational: channel select and message conversion
    // ---------------------------------------------------------------------
    // A channel value loaded in the same cycle is used straight away.
    assign w_c = ch_load ? $signed(ch_llr) : r_ch;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_conv
            // Negating a zero magnitude yields zero, so sign=1/mag=0
            // naturally collapses to 0.
            assign w_m[gi] = Y[gi][4] ? -$signed({2'b00, Y[gi][3:0]})
                                      :  $signed({2'b00, Y[gi][3:0]});
        end
    endgenerate

    // Worst case |total| = 32 + 3*15 = 77, so 8 bits never overflow.
    assign w_total = {{2{w_c[5]}},    w_c}
                   + {{2{w_m[0][5]}}, w_m[0]}
                   + {{2{w_m[1][5]}}, w_m[1]}
                   + {{2{w_m[2][5]}}, w_m[2]};

    // ---------------------------------------------------------------------
    // Stage-2 combinational: extrinsic values
    // ---------------------------------------------------------------------
    generate
        for (gi = 0; gi < 3; gi++) begin : g_extr
            assign w_e[gi]    = r_total - {{2{r_m[gi][5]}}, r_m[gi]};
            assign w_abs[gi]  = w_e[gi][7] ? -w_e[gi] : w_e[gi];
            assign w_sat[gi]  = (w_abs[gi] > 8'd15) ? 4'd15 : w_abs[gi][3:0];
            assign w_omag[gi] = (USE_PHI != 0) ? phi_lut(w_sat[gi]) : w_sat[gi];
            assign X[gi]      = r_x[gi];
        end
    endgenerate

    // Zero counts as positive.
    assign w_hard = r_total[7];

    // ---------------------------------------------------------------------
    // Channel register: follows ch_load regardless of en
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch <= '0;
        end else if (ch_load) begin
            r_ch <= $signed(ch_llr);
        end
    end

    // ---------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_m[i] <= '0;
                r_x[i] <= '0;
            end
            r_total     <= '0;
            r_v1        <= 1'b0;
            r_hard      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (en) begin
            // stage 1: data registers update even for bubbles
            for (int i = 0; i < 3; i++) begin
                r_m[i] <= w_m[i];
            end
            r_total <= w_total;
            r_v1    <= in_valid;
            // stage 2
            for (int i = 0; i < 3; i++) begin
                r_x[i] <= {w_hard, w_e[i][7], w_omag[i]};
            end
            r_hard      <= w_hard;
            r_out_valid <= r_v1;
        end
    end

    // ---------------------------------------------------------------------
    // Iteration counter: a fresh channel load starts a new codeword and
    // wins over a simultaneous output-driven increment.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iter <= '0;
        end else if (ch_load) begin
            r_iter <= '0;
        end else if (en && r_v1) begin
            r_iter <= (r_iter == LAST_ITER) ? 8'd0 : r_iter + 8'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign hard_bit  = r_hard;
    assign iter_cnt  = r_iter;
    assign iter_last = (r_iter == LAST_ITER);

endmodule

// File: tb/tb_vnu_pe.sv
// ---------------------------------------------------------------------------
// tb_vnu_pe : self-checking bench for vnu_pe (USE_PHI=0, MAX_ITER=3).
// Directed vector table, hand-written stall/reset/iteration sequences and
// randomized stimulus, all compared against a behavioural model that works
// in plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_vnu_pe;

    localparam int MAXI = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ch_load;
    logic [5:0] ch_llr;
    logic       in_valid;
    logic [4:0] Y [0:2];
    logic [5:0] X [0:2];
    logic       out_valid;
    logic       hard_bit;
    logic [7:0] iter_cnt;
    logic       iter_last;

    vnu_pe #(.USE_PHI(0), .MAX_ITER(MAXI)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ch_load   (ch_load),
        .ch_llr    (ch_llr),
        .in_valid  (in_valid),
        .Y         (Y),
        .X         (X),
        .out_valid (out_valid),
        .hard_bit  (hard_bit),
        .iter_cnt  (iter_cnt),
        .iter_last (iter_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    typedef struct {
        logic            v;
        logic [2:0][5:0] x;
        logic            hard;
    } res_t;

    res_t in_flight;   // result accepted but not yet visible
    res_t visible;     // result currently expected on the outputs
    int   m_ch;
    int   m_cnt;

    function automatic res_t compute(input int c, input logic [4:0] y0,
                                     input logic [4:0] y1, input logic [4:0] y2,
                                     input logic v);
        res_t       r;
        logic [4:0] ys [3];
        int         m  [3];
        int         tot, e, a;
        ys[0] = y0; ys[1] = y1; ys[2] = y2;
        for (int i = 0; i < 3; i++)
            m[i] = ys[i][4] ? -int'(ys[i][3:0]) : int'(ys[i][3:0]);
        tot    = c + m[0] + m[1] + m[2];
        r.v    = v;
        r.hard = (tot < 0);
        for (int i = 0; i < 3; i++) begin
            e = tot - m[i];
            a = (e < 0) ? -e : e;
            if (a > 15) a = 15;
            r.x[i][5]   = (tot < 0);
            r.x[i][4]   = (e < 0);
            r.x[i][3:0] = 4'(a);
        end
        return r;
    endfunction

    task automatic clear_model();
        in_flight.v = 1'b0; in_flight.x = '0; in_flight.hard = 1'b0;
        visible.v   = 1'b0; visible.x   = '0; visible.hard   = 1'b0;
        m_ch  = 0;
        m_cnt = 0;
    endtask

    // Applies the effect of the coming clock edge given the present inputs.
    task automatic model_edge();
        int c;
        if (!rst_n) begin
            clear_model();
        end else begin
            c = ch_load ? int'($signed(ch_llr)) : m_ch;
            if (ch_load)
                m_cnt = 0;
            else if (en && in_flight.v)
                m_cnt = (m_cnt + 1) % MAXI;
            if (en) begin
                visible   = in_flight;
                in_flight = compute(c, Y[0], Y[1], Y[2], in_valid);
            end
            if (ch_load) m_ch = int'($signed(ch_llr));
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_out_valid", int'(out_valid), int'(visible.v));
        if (visible.v) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("model_X[%0d]", i), int'(X[i]), int'(visible.x[i]));
            chk("model_hard_bit", int'(hard_bit), int'(visible.hard));
        end
        chk("model_iter_cnt", int'(iter_cnt), m_cnt);
        chk("model_iter_last", int'(iter_last), int'(m_cnt == MAXI - 1));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
        if (out_valid)
            $display("out t=%0t X=%b %b %b hard=%0d iter=%0d",
                     $time, X[0], X[1], X[2], hard_bit, iter_cnt);
    endtask

    task automatic set_y(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        Y[0] = a; Y[1] = b; Y[2] = c;
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table
    // ---------------------------------------------------------------------
    typedef struct {
        string      name;
        logic       byp;
        logic [5:0] ch;
        logic [4:0] y0, y1, y2;
        logic [5:0] x0, x1, x2;
        logic       hard;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int iexp [6];
        logic [5:0] exp_x [3];

        vecs[0] = '{"nominal",  1'b0, 6'd10,      5'h03, 5'h02, 5'h11,
                    6'b001011, 6'b001100, 6'b001111, 1'b0};
        vecs[1] = '{"sat_pos",  1'b0, 6'd31,      5'h0F, 5'h0F, 5'h0F,
                    6'b001111, 6'b001111, 6'b001111, 1'b0};
        vecs[2] = '{"sat_neg",  1'b0, 6'b100000,  5'h1F, 5'h1F, 5'h1F,
                    6'b111111, 6'b111111, 6'b111111, 1'b1};
        vecs[3] = '{"zero",     1'b0, 6'd0,       5'h05, 5'h15, 5'h10,
                    6'b010101, 6'b000101, 6'b000000, 1'b0};
        vecs[4] = '{"bypass",   1'b1, 6'b101100,  5'h01, 5'h01, 5'h01,
                    6'b111111, 6'b111111, 6'b111111, 1'b1};

        clear_model();
        rst_n = 1'b0; en = 1'b0; ch_load = 1'b0; ch_llr = '0; in_valid = 1'b0;
        set_y(5'h0, 5'h0, 5'h0);
        tick();
        tick();
        for (int i = 0; i < 3; i++) chk($sformatf("reset_X[%0d]", i), int'(X[i]), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_hard_bit", int'(hard_bit), 0);
        chk("reset_iter_cnt", int'(iter_cnt), 0);
        chk("reset_iter_last", int'(iter_last), 0);
        rst_n = 1'b1;

        // ---- table-driven vectors ----
        foreach (vecs[k]) begin
            if (!vecs[k].byp) begin
                ch_load = 1'b1; ch_llr = vecs[k].ch; en = 1'b0; in_valid = 1'b0;
                tick();
            end
            ch_load = vecs[k].byp; ch_llr = vecs[k].ch; en = 1'b1; in_valid = 1'b1;
            set_y(vecs[k].y0, vecs[k].y1, vecs[k].y2);
            tick();
            ch_load = 1'b0; in_valid = 1'b0;
            tick();
            exp_x[0] = vecs[k].x0; exp_x[1] = vecs[k].x1; exp_x[2] = vecs[k].x2;
            chk({vecs[k].name, "_out_valid"}, int'(out_valid), 1);
            for (int i = 0; i < 3; i++)
                chk($sformatf("%s_X[%0d]", vecs[k].name, i), int'(X[i]), int'(exp_x[i]));
            chk({vecs[k].name, "_hard"}, int'(hard_bit), int'(vecs[k].hard));
            tick();
            chk({vecs[k].name, "_bubble_ov"}, int'(out_valid), 0);
        end

        // ---- stall between stages ----
        ch_load = 1'b1; ch_llr = 6'd10; en = 1'b1; in_valid = 1'b0;
        tick();
        ch_load = 1'b0; in_valid = 1'b1; set_y(5'h03, 5'h02, 5'h11);
        tick();
        in_valid = 1'b0; en = 1'b0;
        tick();
        chk("stall_ov_early", int'(out_valid), 0);
        en = 1'b1;
        tick();
        chk("stall_ov", int'(out_valid), 1);
        chk("stall_X0", int'(X[0]), 6'b001011);
        chk("stall_X2", int'(X[2]), 6'b001111);
        en = 1'b0; set_y(5'h1F, 5'h1F, 5'h1F);
        tick();
        chk("stall_hold_ov", int'(out_valid), 1);
        chk("stall_hold_X1", int'(X[1]), 6'b001100);
        en = 1'b1;
        tick();
        chk("stall_bubble_ov", int'(out_valid), 0);

        // ---- reset with data in stage 1 ----
        in_valid = 1'b1; set_y(5'h03, 5'h02, 5'h11);
        tick();
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) chk($sformatf("midrst_X[%0d]", i), int'(X[i]), 0);
        chk("midrst_ov", int'(out_valid), 0);
        chk("midrst_hard", int'(hard_bit), 0);
        chk("midrst_iter", int'(iter_cnt), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_no_ov", int'(out_valid), 0);
        end

        // ---- iteration counter ----
        ch_load = 1'b1; ch_llr = 6'd5; in_valid = 1'b0; en = 1'b1;
        tick();
        ch_load = 1'b0;
        iexp = '{0, 1, 2, 0, 1, 1};
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 4);
            tick();
            chk($sformatf("iter_cnt_%0d", k), int'(iter_cnt), iexp[k]);
            chk($sformatf("iter_last_%0d", k), int'(iter_last), int'(iexp[k] == 2));
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; ch_load = 1'b1;
        tick();
        chk("iter_load_priority", int'(iter_cnt), 0);
        ch_load = 1'b0;

        // ---- randomized ----
        for (int k = 0; k < 400; k++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            en       = ($urandom_range(0, 3) != 0);
            ch_load  = ($urandom_range(0, 9) == 0);
            ch_llr   = 6'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            set_y(5'($urandom), 5'($urandom), 5'($urandom));
            tick();
        end
        rst_n = 1'b1; en = 1'b1; ch_load = 1'b0; in_valid = 1'b0;
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
